wb_writer: RTL and testbench

//  Writeback-side writer for the 32x32 integer register file. Merges results from the

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_writer_if.sv | 39 +++
 rtl/wb_fifo.sv | 106 ++++++++++
 rtl/wb_writer.sv | 113 +++++++++++
 tb/tb_wb_writer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback writer.
package wb_pkg;

    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned NUM_REGS   = 32;

    localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_WIDTH-1:0] r);
        logic [NUM_REGS-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wb_writer_if.sv
// Writer-side bus: ALU/LSU result inputs, register-file write port, hazard and bypass signals.
interface wb_writer_if #(
    parameter int unsigned ADDR_WIDTH = wb_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = wb_pkg::DATA_WIDTH
);

    logic                      ALU_VALID;
    logic [ADDR_WIDTH-1:0]     ALU_RD;
    logic [DATA_WIDTH-1:0]     ALU_DATA;
    logic                      LSU_VALID;
    logic                      LSU_READY;
    logic [ADDR_WIDTH-1:0]     LSU_RD;
    logic [DATA_WIDTH-1:0]     LSU_DATA;
    logic                      RF_WEN;
    logic [ADDR_WIDTH-1:0]     RF_RD_SEL;
    logic [DATA_WIDTH-1:0]     RF_WB_DATA;
    logic [wb_pkg::NUM_REGS-1:0] PENDING;
    logic [ADDR_WIDTH-1:0]     BYP_RS1_SEL;
    logic [ADDR_WIDTH-1:0]     BYP_RS2_SEL;
    logic                      BYP1_HIT;
    logic [DATA_WIDTH-1:0]     BYP1_DATA;
    logic                      BYP2_HIT;
    logic [DATA_WIDTH-1:0]     BYP2_DATA;

    modport master (
        output ALU_VALID, ALU_RD, ALU_DATA, LSU_VALID, LSU_RD, LSU_DATA,
               BYP_RS1_SEL, BYP_RS2_SEL,
        input  LSU_READY, RF_WEN, RF_RD_SEL, RF_WB_DATA, PENDING,
               BYP1_HIT, BYP1_DATA, BYP2_HIT, BYP2_DATA
    );

    modport slave (
        input  ALU_VALID, ALU_RD, ALU_DATA, LSU_VALID, LSU_RD, LSU_DATA,
               BYP_RS1_SEL, BYP_RS2_SEL,
        output LSU_READY, RF_WEN, RF_RD_SEL, RF_WB_DATA, PENDING,
               BYP1_HIT, BYP1_DATA, BYP2_HIT, BYP2_DATA
    );

endinterface

// File: rtl/wb_fifo.sv
// LSU result buffer with per-register kill; lookup ports exist only with WB_WRITER_BYPASS_EN.
module wb_fifo import wb_pkg::*; #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  push_i,
    input  logic [ADDR_WIDTH-1:0] push_rd_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    input  logic                  kill_en_i,
    input  logic [ADDR_WIDTH-1:0] kill_rd_i,
    output wb_entry_t             head_o,
    output logic                  empty_o,
    output logic                  full_o,
`ifdef WB_WRITER_BYPASS_EN
    input  logic [ADDR_WIDTH-1:0] lk1_sel_i,
    input  logic [ADDR_WIDTH-1:0] lk2_sel_i,
    output logic                  lk1_hit_o,
    output logic [DATA_WIDTH-1:0] lk1_data_o,
    output logic                  lk2_hit_o,
    output logic [DATA_WIDTH-1:0] lk2_data_o,
`endif
    output logic [NUM_REGS-1:0]   live_mask_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Kills are applied before the push so the new entry survives a same-rd kill.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((kill_en_i && mem_q[i].rd == kill_rd_i) || (push_i && mem_q[i].rd == push_rd_i))
                mem_d[i].valid = 1'b0;
        end
        if (pop_i) begin
            mem_d[rd_ptr_q].valid = 1'b0;
            rd_ptr_d              = rd_ptr_q + 1'b1;
        end
        if (push_i) begin
            mem_d[wr_ptr_q] = '{valid: 1'b1, rd: push_rd_i, data: push_data_i};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (push_i && !pop_i)
            count_d = count_q + 1'b1;
        else if (pop_i && !push_i)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

    always_comb begin
        live_mask_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            if (mem_q[i].valid)
                live_mask_o = live_mask_o | reg_onehot(mem_q[i].rd);
    end

`ifdef WB_WRITER_BYPASS_EN
    // At most one live entry per register, so the first match is the only match.
    always_comb begin
        lk1_hit_o  = 1'b0;
        lk1_data_o = '0;
        lk2_hit_o  = 1'b0;
        lk2_data_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (mem_q[i].valid && mem_q[i].rd == lk1_sel_i && lk1_sel_i != REG_ZERO) begin
                lk1_hit_o  = 1'b1;
                lk1_data_o = mem_q[i].data;
            end
            if (mem_q[i].valid && mem_q[i].rd == lk2_sel_i && lk2_sel_i != REG_ZERO) begin
                lk2_hit_o  = 1'b1;
                lk2_data_o = mem_q[i].data;
            end
        end
    end
`endif

endmodule

// File: rtl/wb_writer.sv
// Register-file write-port arbiter: ALU first, buffered LSU results drained in idle slots.
// Optional bypass lookup enabled by defining WB_WRITER_BYPASS_EN.
module wb_writer #(
    parameter int unsigned ADDR_WIDTH = wb_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = wb_pkg::DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic        CLK,
    input logic        RESET,
    wb_writer_if.slave bus
);

    import wb_pkg::*;

    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] sel_q, sel_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic                  alu_wr;
    logic                  push;
    logic                  pop;
    logic                  head_live;
    logic                  fifo_empty;
    logic                  fifo_full;
    wb_entry_t             head;
    logic [NUM_REGS-1:0]   live_mask;

`ifdef WB_WRITER_BYPASS_EN
    logic                  fifo_hit1, fifo_hit2;
    logic [DATA_WIDTH-1:0] fifo_data1, fifo_data2;
    logic                  out_hit1, out_hit2;
`endif

    assign alu_wr    = bus.ALU_VALID && (bus.ALU_RD != REG_ZERO);
    assign push      = bus.LSU_VALID && !fifo_full && (bus.LSU_RD != REG_ZERO);
    assign head_live = !fifo_empty && head.valid;
    // Dead heads drain unconditionally; live heads only when the ALU leaves the slot free.
    assign pop       = !fifo_empty && (!head.valid || !alu_wr);

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK         (CLK),
        .RESET       (RESET),
        .push_i      (push),
        .push_rd_i   (bus.LSU_RD),
        .push_data_i (bus.LSU_DATA),
        .pop_i       (pop),
        .kill_en_i   (alu_wr),
        .kill_rd_i   (bus.ALU_RD),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
`ifdef WB_WRITER_BYPASS_EN
        .lk1_sel_i   (bus.BYP_RS1_SEL),
        .lk2_sel_i   (bus.BYP_RS2_SEL),
        .lk1_hit_o   (fifo_hit1),
        .lk1_data_o  (fifo_data1),
        .lk2_hit_o   (fifo_hit2),
        .lk2_data_o  (fifo_data2),
`endif
        .live_mask_o (live_mask)
    );

    always_comb begin
        wen_d  = 1'b0;
        sel_d  = sel_q;
        data_d = data_q;
        if (alu_wr) begin
            wen_d  = 1'b1;
            sel_d  = bus.ALU_RD;
            data_d = bus.ALU_DATA;
        end else if (head_live) begin
            wen_d  = 1'b1;
            sel_d  = head.rd;
            data_d = head.data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wen_q  <= 1'b0;
            sel_q  <= '0;
            data_q <= '0;
        end else begin
            wen_q  <= wen_d;
            sel_q  <= sel_d;
            data_q <= data_d;
        end
    end

    assign bus.LSU_READY  = !fifo_full;
    assign bus.RF_WEN     = wen_q;
    assign bus.RF_RD_SEL  = sel_q;
    assign bus.RF_WB_DATA = data_q;
    assign bus.PENDING    = (live_mask | (wen_q ? reg_onehot(sel_q) : '0)) & ~NUM_REGS'(1);

`ifdef WB_WRITER_BYPASS_EN
    // A FIFO match is always younger than the output stage, so it takes precedence.
    assign out_hit1      = wen_q && (sel_q == bus.BYP_RS1_SEL) && (bus.BYP_RS1_SEL != REG_ZERO);
    assign out_hit2      = wen_q && (sel_q == bus.BYP_RS2_SEL) && (bus.BYP_RS2_SEL != REG_ZERO);
    assign bus.BYP1_HIT  = fifo_hit1 || out_hit1;
    assign bus.BYP2_HIT  = fifo_hit2 || out_hit2;
    assign bus.BYP1_DATA = fifo_hit1 ? fifo_data1 : (out_hit1 ? data_q : '0);
    assign bus.BYP2_DATA = fifo_hit2 ? fifo_data2 : (out_hit2 ? data_q : '0);
`else
    logic unused_byp_sel;
    assign unused_byp_sel = ^{bus.BYP_RS1_SEL, bus.BYP_RS2_SEL};
    assign bus.BYP1_HIT   = 1'b0;
    assign bus.BYP2_HIT   = 1'b0;
    assign bus.BYP1_DATA  = '0;
    assign bus.BYP2_DATA  = '0;
`endif

endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer; expectations follow WB_WRITER_BYPASS_EN when defined.
module tb_wb_writer;

    logic CLK = 1'b0;
    logic RESET;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    wb_writer_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    wb_writer #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        bus.ALU_VALID = av;
        bus.ALU_RD    = ard;
        bus.ALU_DATA  = ad;
        bus.LSU_VALID = lv;
        bus.LSU_RD    = lrd;
        bus.LSU_DATA  = ld;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    function automatic logic [31:0] hit_exp(input logic h);
`ifdef WB_WRITER_BYPASS_EN
        return {31'b0, h};
`else
        return 32'h0 & {31'b0, h};
`endif
    endfunction

    function automatic logic [31:0] dat_exp(input logic [31:0] d);
`ifdef WB_WRITER_BYPASS_EN
        return d;
`else
        return 32'h0 & d;
`endif
    endfunction

    initial begin
        logic [31:0] mask;
        RESET           = 1'b1;
        bus.BYP_RS1_SEL = 5'd0;
        bus.BYP_RS2_SEL = 5'd0;
        idle();

        // 1: reset state
        tick();
        tick();
        check("rst_wen", {31'b0, bus.RF_WEN}, 32'h0);
        check("rst_ready", {31'b0, bus.LSU_READY}, 32'h1);
        check("rst_pending", bus.PENDING, 32'h0);
        check("rst_sel", {27'b0, bus.RF_RD_SEL}, 32'h0);
        check("rst_data", bus.RF_WB_DATA, 32'h0);
        RESET = 1'b0;

        // 2: ALU write, latency 1, then hold
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        tick();
        idle();
        check("alu_wen", {31'b0, bus.RF_WEN}, 32'h1);
        check("alu_sel", {27'b0, bus.RF_RD_SEL}, 32'd5);
        check("alu_data", bus.RF_WB_DATA, 32'hDEADBEEF);
        check("alu_pending", bus.PENDING, 32'h0000_0020);
        tick();
        check("alu_idle_wen", {31'b0, bus.RF_WEN}, 32'h0);
        check("alu_hold_sel", {27'b0, bus.RF_RD_SEL}, 32'd5);
        check("alu_hold_data", bus.RF_WB_DATA, 32'hDEADBEEF);
        check("alu_idle_pending", bus.PENDING, 32'h0);

        // 3: x0 writes from both sources
        drive(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h5678);
        #1;
        check("x0_ready", {31'b0, bus.LSU_READY}, 32'h1);
        tick();
        idle();
        check("x0_wen", {31'b0, bus.RF_WEN}, 32'h0);
        check("x0_pending", bus.PENDING, 32'h0);
        tick();
        check("x0_no_drain", {31'b0, bus.RF_WEN}, 32'h0);
        check("x0_ready2", {31'b0, bus.LSU_READY}, 32'h1);

        // 4: fill FIFO under ALU pressure, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'(20 + i), 32'(i), 1'b1, 5'(i + 1), 32'((i + 1) * 16));
            tick();
            check("fill_alu_sel", {27'b0, bus.RF_RD_SEL}, 32'(20 + i));
        end
        idle();
        check("fill_ready", {31'b0, bus.LSU_READY}, 32'h0);
        check("fill_pending", bus.PENDING, 32'h0080_001E);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drain_wen", {31'b0, bus.RF_WEN}, 32'h1);
            check("drain_sel", {27'b0, bus.RF_RD_SEL}, 32'(i + 1));
            check("drain_data", bus.RF_WB_DATA, 32'((i + 1) * 16));
            check("drain_ready", {31'b0, bus.LSU_READY}, 32'h1);
            mask = 32'h0;
            for (int j = i + 1; j <= 4; j++) mask[j] = 1'b1;
            check("drain_pending", bus.PENDING, mask);
        end
        tick();
        check("drain_done_wen", {31'b0, bus.RF_WEN}, 32'h0);
        check("drain_done_pending", bus.PENDING, 32'h0);

        // 5: queued LSU x7 killed by later ALU x7
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h11);
        tick();
        drive(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'h0);
        check("kill_pend_before", bus.PENDING, 32'h0000_0088);
        tick();
        idle();
        check("kill_wen", {31'b0, bus.RF_WEN}, 32'h1);
        check("kill_sel", {27'b0, bus.RF_RD_SEL}, 32'd7);
        check("kill_data", bus.RF_WB_DATA, 32'h22);
        check("kill_pend_out", bus.PENDING, 32'h0000_0080);
        tick();
        check("kill_no_lsu_wen", {31'b0, bus.RF_WEN}, 32'h0);
        check("kill_pend_clear", bus.PENDING, 32'h0);
        check("kill_hold_data", bus.RF_WB_DATA, 32'h22);
        tick();
        check("kill_still_idle", {31'b0, bus.RF_WEN}, 32'h0);

        // 6: bypass lookups (FIFO entry and output stage)
        drive(1'b1, 5'd2, 32'h5, 1'b1, 5'd9, 32'h99);
        tick();
        drive(1'b1, 5'd2, 32'h6, 1'b0, 5'd0, 32'h0);
        bus.BYP_RS1_SEL = 5'd9;
        bus.BYP_RS2_SEL = 5'd2;
        #1;
        check("byp1_hit", {31'b0, bus.BYP1_HIT}, hit_exp(1'b1));
        check("byp1_data", bus.BYP1_DATA, dat_exp(32'h99));
        check("byp2_hit_out", {31'b0, bus.BYP2_HIT}, hit_exp(1'b1));
        check("byp2_data_out", bus.BYP2_DATA, dat_exp(32'h5));
        bus.BYP_RS1_SEL = 5'd0;
        bus.BYP_RS2_SEL = 5'd11;
        #1;
        check("byp_x0_miss", {31'b0, bus.BYP1_HIT}, 32'h0);
        check("byp_miss", {31'b0, bus.BYP2_HIT}, 32'h0);
        tick();
        idle();
        tick();
        check("byp_drain_sel", {27'b0, bus.RF_RD_SEL}, 32'd9);
        check("byp_drain_data", bus.RF_WB_DATA, 32'h99);
        tick();

        // 7: same-cycle ALU and LSU to x12: ALU first, LSU later
        drive(1'b1, 5'd12, 32'hA, 1'b1, 5'd12, 32'hB);
        tick();
        idle();
        bus.BYP_RS1_SEL = 5'd12;
        #1;
        check("waw_first_data", bus.RF_WB_DATA, 32'hA);
        check("waw_pending", bus.PENDING, 32'h0000_1000);
        check("waw_byp_fifo_wins", bus.BYP1_DATA, dat_exp(32'hB));
        tick();
        check("waw_second_wen", {31'b0, bus.RF_WEN}, 32'h1);
        check("waw_second_data", bus.RF_WB_DATA, 32'hB);
        tick();
        check("waw_done", {31'b0, bus.RF_WEN}, 32'h0);
        bus.BYP_RS1_SEL = 5'd0;

        // 8: reset mid-operation discards queued results
        drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66);
        tick();
        drive(1'b1, 5'd5, 32'h56, 1'b1, 5'd8, 32'h88);
        tick();
        idle();
        RESET = 1'b1;
        tick();
        check("mid_rst_wen", {31'b0, bus.RF_WEN}, 32'h0);
        check("mid_rst_pending", bus.PENDING, 32'h0);
        check("mid_rst_data", bus.RF_WB_DATA, 32'h0);
        RESET = 1'b0;
        tick();
        check("post_rst_wen", {31'b0, bus.RF_WEN}, 32'h0);
        tick();
        check("post_rst_wen2", {31'b0, bus.RF_WEN}, 32'h0);

        // 9: younger LSU enqueue kills older queued entry to same rd
        drive(1'b1, 5'd20, 32'h1, 1'b1, 5'd10, 32'h1);
        tick();
        drive(1'b1, 5'd21, 32'h2, 1'b1, 5'd10, 32'h2);
        tick();
        idle();
        tick();
        check("enq_kill_dead_pop", {31'b0, bus.RF_WEN}, 32'h0);
        check("enq_kill_pending", bus.PENDING, 32'h0000_0400);
        tick();
        check("enq_kill_wen", {31'b0, bus.RF_WEN}, 32'h1);
        check("enq_kill_sel", {27'b0, bus.RF_RD_SEL}, 32'd10);
        check("enq_kill_data", bus.RF_WB_DATA, 32'h2);
        tick();
        check("enq_kill_done", {31'b0, bus.RF_WEN}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
